// File: rtl/version_reporter.sv
// Reads the version-string window top word first and streams its non-zero bytes, MSB first, to the UART TX.
// Define VERSION_REPORTER_CRLF_EN to append CR/LF after the string.
//
// state   | meaning
// IDLE    | waiting for start_i
// REQ     | requesting the bus, waiting for grant
// ADDR    | driving the word address
// CAPTURE | latching read data into the shift register
// EMIT    | presenting bytes to the UART, skipping zero pad bytes
// CR      | sending carriage return (CRLF build only)
// LF      | sending line feed (CRLF build only)
// DONE    | one-cycle completion pulse
module version_reporter #(
  parameter int BaseAddress   = 0,
  parameter int NumCharacters = 44,
  parameter int address_width = 15,
  parameter int data_width    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     bus_req_o,
  input  logic                     bus_gnt_i,
  output logic [address_width-1:0] address_o,
  output logic                     rd_wr_o,
  input  logic [data_width-1:0]    data_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i
);

  localparam int Bpw      = data_width / 8;
  localparam int NumWords = (NumCharacters + Bpw - 1) / Bpw;
  localparam int WordIdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int ByteIdxW = (Bpw > 1) ? $clog2(Bpw) : 1;
  localparam logic [WordIdxW-1:0] LastWord = WordIdxW'(NumWords - 1);
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(Bpw - 1);

`ifdef VERSION_REPORTER_CRLF_EN
  typedef enum logic [2:0] {IDLE, REQ, ADDR, CAPTURE, EMIT, CR, LF, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, ADDR, CAPTURE, EMIT, DONE} state_t;
`endif

  state_t                state;
  logic [WordIdxW-1:0]   word_idx;
  logic [ByteIdxW-1:0]   byte_idx;
  logic [data_width-1:0] shreg;
  logic [data_width-1:0] shreg_shifted;
  logic [7:0]            next_byte;
  logic [7:0]            cap_byte;

  assign shreg_shifted = shreg << 8;
  assign next_byte     = shreg_shifted[data_width-1 -: 8];
  assign cap_byte      = data_i[data_width-1 -: 8];
  assign rd_wr_o       = 1'b0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      word_idx   <= LastWord;
      byte_idx   <= '0;
      shreg      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      bus_req_o  <= 1'b0;
      address_o  <= '0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state     <= REQ;
          busy_o    <= 1'b1;
          bus_req_o <= 1'b1;
        end
        REQ: if (bus_gnt_i) begin
          state     <= ADDR;
          address_o <= address_width'(BaseAddress) + address_width'(word_idx);
        end
        ADDR: state <= CAPTURE;
        CAPTURE: begin
          shreg      <= data_i;
          byte_idx   <= '0;
          tx_data_o  <= cap_byte;
          tx_valid_o <= |cap_byte;
          bus_req_o  <= 1'b0;
          address_o  <= '0;
          state      <= EMIT;
        end
        // A zero byte has tx_valid_o low, so it advances without a handshake.
        EMIT: if (!tx_valid_o || tx_ready_i) begin
          shreg    <= shreg_shifted;
          byte_idx <= byte_idx + ByteIdxW'(1);
          if (byte_idx != LastByte) begin
            tx_data_o  <= next_byte;
            tx_valid_o <= |next_byte;
          end else if (word_idx != '0) begin
            word_idx   <= word_idx - WordIdxW'(1);
            tx_valid_o <= 1'b0;
            bus_req_o  <= 1'b1;
            state      <= REQ;
          end else begin
`ifdef VERSION_REPORTER_CRLF_EN
            tx_data_o  <= 8'h0D;
            tx_valid_o <= 1'b1;
            state      <= CR;
`else
            tx_valid_o <= 1'b0;
            done_o     <= 1'b1;
            state      <= DONE;
`endif
          end
        end
`ifdef VERSION_REPORTER_CRLF_EN
        CR: if (tx_ready_i) begin
          tx_data_o <= 8'h0A;
          state     <= LF;
        end
        LF: if (tx_ready_i) begin
          tx_valid_o <= 1'b0;
          done_o     <= 1'b1;
          state      <= DONE;
        end
`endif
        DONE: begin
          done_o   <= 1'b0;
          busy_o   <= 1'b0;
          word_idx <= LastWord;
          byte_idx <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_version_reporter.sv
// Self-checking bench for version_reporter: 3-word window of 16-bit words,
// byte scoreboard built from the window contents plus directed literal checks.
module tb_version_reporter;

  localparam int NW = 3;

  logic        clk_i = 1'b0;
  logic        reset_i, start_i, bus_gnt_i, tx_ready_i;
  logic        busy_o, done_o, bus_req_o, rd_wr_o, tx_valid_o;
  logic [14:0] address_o;
  logic [15:0] data_i;
  logic [7:0]  tx_data_o;

  logic [15:0] mem [0:3];
  assign data_i = mem[address_o[1:0]];

  version_reporter #(
    .BaseAddress(0), .NumCharacters(6), .address_width(15), .data_width(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o),
    .done_o(done_o), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
    .address_o(address_o), .rd_wr_o(rd_wr_o), .data_i(data_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         exp_addr_q[$];
  int         exp_len;
  int         done_cnt;
  int         tx_cnt;
  logic [7:0] first_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected stream: words from the top address down, bytes MSB first, zero bytes dropped.
  task automatic build_model();
    exp_q.delete();
    exp_addr_q.delete();
    for (int w = NW - 1; w >= 0; w--) begin
      exp_addr_q.push_back(w);
      for (int b = 1; b >= 0; b--)
        if (mem[w][b*8 +: 8] != 8'h00) exp_q.push_back(mem[w][b*8 +: 8]);
    end
`ifdef VERSION_REPORTER_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    exp_len = exp_q.size();
  endtask

  logic       prev_valid, prev_ready, prev_req, prev_done;
  logic [7:0] prev_data;
  logic [14:0] prev_addr;

  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_valid = 0; prev_ready = 0; prev_req = 0; prev_done = 0;
      prev_data = 0; prev_addr = 0;
    end else begin
      check("rd_wr", rd_wr_o, 0);
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) check("extra_byte", tx_data_o, 32'hFFFF_FFFF);
        else check("tx_byte", tx_data_o, exp_q.pop_front());
        if (tx_cnt == 0) first_byte = tx_data_o;
        tx_cnt++;
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", tx_valid_o, 1);
        check("hold_data", tx_data_o, prev_data);
      end
      if (prev_req && !bus_req_o) begin
        if (exp_addr_q.size() == 0) check("extra_read", prev_addr, 32'hFFFF_FFFF);
        else check("read_addr", prev_addr, exp_addr_q.pop_front());
      end
      if (bus_req_o && !bus_gnt_i) check("addr_ungranted", address_o, 0);
      if (prev_done) check("busy_after_done", busy_o, 0);
      if (done_o) begin
        check("busy_at_done", busy_o, 1);
        done_cnt++;
      end
      prev_valid = tx_valid_o; prev_ready = tx_ready_i; prev_data = tx_data_o;
      prev_req = bus_req_o; prev_addr = address_o; prev_done = done_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_req"}, bus_req_o, 0);
    check({tag, "_addr"}, address_o, 0);
    check({tag, "_rdwr"}, rd_wr_o, 0);
    check({tag, "_txdata"}, tx_data_o, 0);
    check({tag, "_txvalid"}, tx_valid_o, 0);
  endtask

  task automatic run_string(input int gnt_delay, input bit bp, input bit extra_start, input bit lat_check);
    int cyc;
    int first_valid;
    bit bp_done;
    build_model();
    done_cnt = 0; tx_cnt = 0; first_valid = -1; bp_done = 0;
    start_i = 1; bus_gnt_i = (gnt_delay == 0);
    @(posedge clk_i); #1;
    start_i = 0; cyc = 1;
    check("req_latency", bus_req_o, 1);
    check("busy_latency", busy_o, 1);
    repeat (gnt_delay) begin
      check("req_hold", bus_req_o, 1);
      check("addr_before_gnt", address_o, 0);
      @(posedge clk_i); #1; cyc++;
    end
    bus_gnt_i = 1;
    while (!done_o && cyc < 300) begin
      if (tx_valid_o && first_valid < 0) first_valid = cyc;
      start_i = (extra_start && cyc == 6);
      if (bp && !bp_done && tx_cnt == 1 && tx_valid_o) begin
        bp_done = 1;
        tx_ready_i = 0;
        repeat (5) begin
          @(posedge clk_i); #1; cyc++;
          check("bp_valid", tx_valid_o, 1);
          check("bp_data", tx_data_o, 8'h31);
        end
        tx_ready_i = 1;
      end
      @(posedge clk_i); #1; cyc++;
    end
    start_i = 0;
    check("done_reached", done_o, 1);
    if (lat_check) check("first_valid_cycle", first_valid, 4);
    @(posedge clk_i); #1;
    check("busy_fall", busy_o, 0);
    check("done_single", done_o, 0);
    repeat (2) begin @(posedge clk_i); #1; end
    check("bytes_pending", exp_q.size(), 0);
    check("reads_pending", exp_addr_q.size(), 0);
    check("byte_count", tx_cnt, exp_len);
    check("done_count", done_cnt, 1);
  endtask

  task automatic load_v12();
    mem[0] = 16'h2E32; mem[1] = 16'h7631; mem[2] = 16'h0000; mem[3] = 16'h0000;
  endtask

  initial begin
    reset_i = 1; start_i = 0; bus_gnt_i = 1; tx_ready_i = 1;
    done_cnt = 0; tx_cnt = 0; first_byte = 0; exp_len = 0;
    for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    reset_i = 0;
    @(posedge clk_i); #1;

    // "v1.2" with a zero-pad top word
    load_v12();
    build_model();
    check("model_len_v12", exp_len, 4 + (exp_q.size() - 4));
    check("model_v12", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}, 32'h76312E32);
    run_string(0, 0, 0, 0);
    check("first_byte_v12", first_byte, 8'h76);

    // Latency with a non-empty top word and a zero byte in the middle
    mem[2] = 16'h4142; mem[1] = 16'h0043; mem[0] = 16'h4400;
    build_model();
    check("model_mid_zero", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}, 32'h41424344);
    run_string(0, 0, 0, 1);

    load_v12();
    run_string(0, 1, 0, 0);   // backpressure on second byte
    run_string(7, 0, 0, 0);   // grant delay
    run_string(0, 0, 1, 0);   // start while busy
    check("ignored_start_bytes", tx_cnt, exp_len);

    for (int i = 0; i < 4; i++) mem[i] = 16'h0000;
    run_string(0, 0, 0, 0);   // all-zero string

    // Reset while a byte is presented
    load_v12();
    build_model();
    tx_cnt = 0;
    start_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
    for (int i = 0; i < 50 && !(tx_cnt >= 1 && tx_valid_o); i++) begin
      @(posedge clk_i); #1;
    end
    check("mid_wait_valid", tx_valid_o, 1);
    reset_i = 1;
    @(posedge clk_i); #1;
    check_reset_outputs("midreset");
    reset_i = 0;
    @(posedge clk_i); #1;
    run_string(0, 0, 0, 0);
    check("replay_first", first_byte, 8'h76);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
